// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-entry pending (scoreboard) bit,
// write-through bypass on reads and optional hardwired-zero entry 0.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam bit          HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;

    // Writes and reservations aimed at a hardwired-zero entry are dropped
    always_comb begin
        wr_ok  = we;
        rsv_ok = rsv_en;
        if (HAS_ZERO && (wr_addr == '0)) begin
            wr_ok = 1'b0;
        end
        if (HAS_ZERO && (rsv_addr == '0)) begin
            rsv_ok = 1'b0;
        end
    end

    // Data storage: async clear, one write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pending-bit update: write clears, reserve sets, and set wins on collision
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Pending-bit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    // Per-port combinational read with write-through bypass
    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;

        assign ra       = rd_addr[p*ADDR_W +: ADDR_W];
        assign zero_hit = HAS_ZERO && (ra == '0);
        assign byp_hit  = wr_ok && (wr_addr == ra);

        // Operand select and readiness for this port
        always_comb begin
            rd_data[p*DATA_W +: DATA_W] = mem[ra];
            rd_ready[p]                 = ~busy[ra];
            if (zero_hit) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
                rd_ready[p]                 = 1'b1;
            end else if (byp_hit) begin
                rd_data[p*DATA_W +: DATA_W] = wr_data;
                rd_ready[p]                 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors with a queue-based scoreboard and decoupled monitor.
module tb_regfile_sb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic                     rsv_en = 1'b0;
    logic [ADDR_W-1:0]        rsv_addr = '0;

    logic [NUM_RD*DATA_W-1:0] rd_data_z, rd_data_n;
    logic [NUM_RD-1:0]        rd_ready_z, rd_ready_n;
    logic [DEPTH-1:0]         busy_z, busy_n;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_ready(rd_ready_z),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_z)
    );

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_n)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd_data[idx], 1 = rd_ready[idx], 2 = busy_vec[idx], 3 = whole busy_vec
    typedef struct {
        int          kind;
        bit          nz;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_v(input int kind, input bit nz, input int idx,
                            input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind; e.nz = nz; e.idx = idx; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    // Hand the queued expectations to the monitor, sampling 1 ns after inputs settle
    task automatic sample();
        #1;
        -> chk_ev;
        #0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_addr = {ADDR_W'(p1), ADDR_W'(p0)};
    endtask

    // Monitor: pop every pending expectation and compare against the DUT output
    always begin
        @(chk_ev);
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0: act = e.nz ? rd_data_n[e.idx*DATA_W +: DATA_W] : rd_data_z[e.idx*DATA_W +: DATA_W];
                1: act = 32'(e.nz ? rd_ready_n[e.idx] : rd_ready_z[e.idx]);
                2: act = 32'(e.nz ? busy_n[e.idx] : busy_z[e.idx]);
                default: act = e.nz ? busy_n : busy_z;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        // Reset: every address on every port reads 0/ready, no pending bits
        for (int a = 0; a < int'(DEPTH); a++) begin
            set_rd(a, (a + 1) % DEPTH);
            expect_v(0, 0, 0, 32'h0, "rst_data0");
            expect_v(0, 0, 1, 32'h0, "rst_data1");
            expect_v(1, 0, 0, 32'h1, "rst_rdy0");
            expect_v(1, 0, 1, 32'h1, "rst_rdy1");
            expect_v(0, 1, 0, 32'h0, "rst_data0_nz");
            sample();
        end
        expect_v(3, 0, 0, 32'h0, "rst_busy");
        expect_v(3, 1, 0, 32'h0, "rst_busy_nz");
        sample();
        @(negedge clk) rst_n = 1'b1;

        // Same-cycle write-through to entry 5, then stored value
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5, 6);
        expect_v(0, 0, 0, 32'hDEADBEEF, "byp_5");
        expect_v(1, 0, 0, 32'h1, "byp_5_rdy");
        expect_v(0, 0, 1, 32'h0, "byp_6_untouched");
        sample();
        @(negedge clk);
        we = 1'b0;
        expect_v(0, 0, 0, 32'hDEADBEEF, "stored_5");
        sample();

        // Entry 0: hardwired zero vs ordinary storage, including no bypass on zero
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; set_rd(0, 5);
        expect_v(0, 0, 0, 32'h0, "zero_byp");
        expect_v(0, 1, 0, 32'h1234, "nz_byp");
        sample();
        @(negedge clk);
        we = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        expect_v(0, 0, 0, 32'h0, "zero_read");
        expect_v(1, 0, 0, 32'h1, "zero_rdy");
        expect_v(0, 1, 0, 32'h1234, "nz_read");
        expect_v(0, 1, 1, 32'hDEADBEEF, "nz_read5");
        sample();
        @(negedge clk);
        rsv_en = 1'b0;
        expect_v(2, 0, 0, 32'h0, "zero_rsv_ignored");
        expect_v(1, 0, 0, 32'h1, "zero_rsv_rdy");
        expect_v(2, 1, 0, 32'h1, "nz_rsv_0");
        expect_v(1, 1, 0, 32'h0, "nz_rsv_0_rdy");
        sample();

        // Reserve 7, observe hazard, resolve with write of 0xA5
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        rsv_en = 1'b0; set_rd(7, 7);
        expect_v(1, 0, 0, 32'h0, "rsv7_rdy");
        expect_v(1, 0, 1, 32'h0, "rsv7_rdy1");
        expect_v(2, 0, 7, 32'h1, "rsv7_busy");
        sample();
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        expect_v(1, 0, 0, 32'h1, "wr7_rdy_byp");
        expect_v(0, 0, 0, 32'hA5, "wr7_data_byp");
        expect_v(2, 0, 7, 32'h1, "wr7_busy_registered");
        sample();
        @(negedge clk);
        we = 1'b0;
        expect_v(2, 0, 7, 32'h0, "wr7_busy_clr");
        expect_v(0, 0, 1, 32'hA5, "wr7_stored");
        expect_v(1, 0, 1, 32'h1, "wr7_rdy");
        sample();

        // Same-edge reserve and write to entry 3: set wins, data written
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd3; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        @(negedge clk);
        rsv_en = 1'b0; we = 1'b0; set_rd(3, 3);
        expect_v(0, 0, 0, 32'h55, "col3_data");
        expect_v(0, 0, 1, 32'h55, "col3_data1");
        expect_v(1, 0, 0, 32'h0, "col3_rdy");
        expect_v(2, 0, 3, 32'h1, "col3_busy");
        sample();

        // Different addresses on the same edge; re-reserve of a busy entry stays busy
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd12; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        rsv_en = 1'b0; set_rd(3, 12);
        expect_v(2, 0, 12, 32'h1, "rsv12_busy");
        expect_v(1, 0, 1, 32'h0, "rsv12_rdy");
        expect_v(2, 0, 3, 32'h0, "wr3_busy_clr");
        expect_v(0, 0, 0, 32'h66, "wr3_data");
        expect_v(1, 0, 0, 32'h1, "wr3_rdy");
        sample();

        // Reserve 9, write 10, then async reset mid-cycle
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        @(negedge clk);
        rsv_en = 1'b0; we = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
        @(negedge clk);
        we = 1'b0; set_rd(9, 10);
        expect_v(2, 0, 9, 32'h1, "pre_rst_busy9");
        expect_v(0, 0, 1, 32'h77, "pre_rst_data10");
        sample();
        #1 rst_n = 1'b0;
        expect_v(3, 0, 0, 32'h0, "async_rst_busy");
        expect_v(0, 0, 1, 32'h0, "async_rst_data10");
        expect_v(1, 0, 0, 32'h1, "async_rst_rdy9");
        sample();
        // Bypass still visible in reset, but the write does not land
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        expect_v(0, 0, 1, 32'h99, "rst_byp10");
        expect_v(1, 0, 1, 32'h1, "rst_byp10_rdy");
        sample();
        @(negedge clk);
        we = 1'b0; rsv_en = 1'b0;
        expect_v(0, 0, 1, 32'h0, "rst_wr_ignored");
        expect_v(3, 0, 0, 32'h0, "rst_rsv_ignored");
        sample();
        @(negedge clk);
        rst_n = 1'b1; we = 1'b1; wr_addr = 5'd10; wr_data = 32'hBB;
        @(negedge clk);
        we = 1'b0;
        expect_v(0, 0, 1, 32'hBB, "first_wr_after_rst");
        expect_v(2, 0, 10, 32'h0, "busy10_after_rst");
        sample();

        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, legal 1..4: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: 1 = entry 0 hardwired to zero; 0 = entry 0 is ordinary storage.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
REQ-010 rd_ready  out  NUM_RD  port i operand valid (not pending).
REQ-011 we  in  1  write enable.
REQ-012 wr_addr  in  ADDR_W  write address.
REQ-013 wr_data  in  DATA_W  write data.
REQ-014 rsv_en  in  1  reserve (mark pending) request.
REQ-015 rsv_addr  in  ADDR_W  register to reserve.
REQ-016 busy_vec  out  2**ADDR_W  current pending bit per entry.

Function
REQ-017 Write SHALL commit wr_data to entry wr_addr on the rising clk edge when we=1; one-cycle write latency.
REQ-018 With ZERO_REG=1, writes and reservations to entry 0 SHALL be ignored; reads of entry 0 SHALL return 0 and rd_ready=1.
REQ-019 Reads SHALL be combinational (zero latency) from storage for every port independently; multiple ports may read the same address.
REQ-020 Write-through bypass: when we=1 and wr_addr equals rd_addr[i] (and is not a hardwired zero entry), rd_data[i] SHALL equal wr_data in the same cycle.
REQ-021 busy bit of entry rsv_addr SHALL set on the rising edge when rsv_en=1.
REQ-022 busy bit of entry wr_addr SHALL clear on the rising edge when we=1.
REQ-023 Same-edge rsv_en and we to the same address: set wins (busy=1 after edge, data still written).
REQ-024 Same-edge rsv_en and we to different addresses: both take effect.
REQ-025 rd_ready[i] SHALL be 1 when busy[rd_addr[i]]=0, or when we=1 and wr_addr=rd_addr[i] (bypass resolves the hazard).
REQ-026 Reserving an already-busy entry SHALL leave it busy; writing a non-busy entry SHALL update data and leave busy=0.
REQ-027 busy_vec SHALL reflect registered busy state only (no combinational bypass).
REQ-028 Address arithmetic SHALL use all ADDR_W bits; no aliasing, no out-of-range entries exist.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, clear all entries to 0 and all busy bits to 0.
REQ-030 During reset rd_data SHALL read 0 on every port except via bypass when we=1; rd_ready SHALL be 1 except where REQ-025 bypass applies; writes and reservations SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations; first write accepted on the first rising edge with rst_n=1.

Verification
REQ-032 Reset then read all addresses on all ports -> rd_data=0, rd_ready all 1, busy_vec=0.
REQ-033 we=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF before and after edge.
REQ-034 Write 0x1234 to entry 0 with ZERO_REG=1 -> read entry 0 returns 0; with ZERO_REG=0 returns 0x1234.
REQ-035 rsv_en to 7, next cycle read 7 -> rd_ready=0, busy_vec[7]=1; then we to 7 with 0xA5 -> rd_ready=1 and data 0xA5 in write cycle, busy_vec[7]=0 after edge.
REQ-036 Same edge rsv_en=1, rsv_addr=3 and we=1, wr_addr=3, wr_data=0x55 -> entry 3 holds 0x55, busy_vec[3]=1.
REQ-037 Reserve 9, write 0x77 to 10, assert rst_n=0 mid-cycle -> busy_vec=0 and entry 10 reads 0 immediately, no clock required.
